// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - accumulates TAPS unsigned products per window into a one-entry valid/ready output register
module mac_accumulator #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 72,
  parameter int TAPS       = 9,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    prod_valid,
  input  logic [2*DATA_WIDTH-1:0] prod,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [ACC_WIDTH-1:0]    acc_out,
  output logic [CNT_WIDTH-1:0]    tap_cnt,
  output logic                    busy,
  output logic                    overflow
);

  typedef enum logic {
    S_EMPTY,
    S_ACCUM
  } win_state_e;

  localparam logic [CNT_WIDTH-1:0] LAST_TAP = CNT_WIDTH'(TAPS - 1);

  win_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]   tap_cnt_q, tap_cnt_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [ACC_WIDTH-1:0]   acc_out_q, acc_out_d;
  logic                   out_valid_q, out_valid_d;
  logic                   overflow_q, overflow_d;
  logic [ACC_WIDTH-1:0]   prod_ext;
  logic [ACC_WIDTH-1:0]   win_sum;
  logic                   final_tap;
  logic                   handshake;

  assign prod_ext  = ACC_WIDTH'(prod);
  // The first tap of a window starts a fresh sum instead of adding to stale acc.
  assign win_sum   = (state_q == S_EMPTY) ? prod_ext : acc_q + prod_ext;
  assign final_tap = prod_valid && (tap_cnt_q == LAST_TAP);
  assign handshake = out_valid_q && out_ready;

  always_comb begin
    state_d   = state_q;
    tap_cnt_d = tap_cnt_q;
    acc_d     = acc_q;
    if (clear) begin
      state_d   = S_EMPTY;
      tap_cnt_d = '0;
      acc_d     = '0;
    end else if (prod_valid) begin
      case (state_q)
        S_EMPTY: begin
          if (final_tap) begin
            acc_d = '0;
          end else begin
            state_d   = S_ACCUM;
            tap_cnt_d = CNT_WIDTH'(1);
            acc_d     = win_sum;
          end
        end
        S_ACCUM: begin
          if (final_tap) begin
            state_d   = S_EMPTY;
            tap_cnt_d = '0;
            acc_d     = '0;
          end else begin
            tap_cnt_d = tap_cnt_q + CNT_WIDTH'(1);
            acc_d     = win_sum;
          end
        end
        default: begin
          state_d   = S_EMPTY;
          tap_cnt_d = '0;
          acc_d     = '0;
        end
      endcase
    end
  end

  // A completion may reuse the slot only if it is empty or being retired this cycle.
  always_comb begin
    out_valid_d = out_valid_q;
    acc_out_d   = acc_out_q;
    overflow_d  = overflow_q;
    if (clear) begin
      out_valid_d = 1'b0;
      overflow_d  = 1'b0;
    end else if (final_tap) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        acc_out_d   = win_sum;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (handshake) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      tap_cnt_q   <= '0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_cnt_q   <= tap_cnt_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign acc_out   = acc_out_q;
  assign tap_cnt   = tap_cnt_q;
  assign busy      = (tap_cnt_q != '0);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - vector table, corner sequences and random model check for mac_accumulator
module tb_mac_accumulator;
  localparam int DW   = 32;
  localparam int AW   = 72;
  localparam int TAPS = 9;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          prod_valid = 1'b0;
  logic [2*DW-1:0] prod = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [AW-1:0] acc_out;
  logic [CW-1:0] tap_cnt;
  logic          busy;
  logic          overflow;

  mac_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .TAPS(TAPS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(prod_valid), .prod(prod),
    .out_ready(out_ready), .out_valid(out_valid), .acc_out(acc_out), .tap_cnt(tap_cnt),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic          clr;
    logic          pv;
    logic [63:0]   p;
    logic          rdy;
    logic          ev;
    logic [AW-1:0] eacc;
    logic [CW-1:0] etap;
    logic          eovf;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic c, input logic pv, input logic [63:0] p, input logic r);
    clear      = c;
    prod_valid = pv;
    prod       = p;
    out_ready  = r;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic c, input logic pv, input logic [63:0] p, input logic r,
                              input logic ev, input logic [AW-1:0] eacc, input int etap, input logic eovf);
    vec_t v;
    v.clr = c; v.pv = pv; v.p = p; v.rdy = r;
    v.ev = ev; v.eacc = eacc; v.etap = CW'(etap); v.eovf = eovf;
    tbl.push_back(v);
  endfunction

  // reference model state: taps are counted 1..TAPS per window
  int            m_cnt;
  logic [AW-1:0] m_sum;
  logic [AW-1:0] m_out;
  logic          m_valid;
  logic          m_ovf;

  function automatic void model_step(input logic c, input logic pv, input logic [63:0] p, input logic r);
    logic done;
    done = 1'b0;
    if (c) begin
      m_cnt = 0; m_sum = '0; m_valid = 1'b0; m_ovf = 1'b0;
      return;
    end
    if (pv) begin
      m_sum = (m_cnt == 0) ? AW'(p) : m_sum + AW'(p);
      m_cnt = m_cnt + 1;
      if (m_cnt == TAPS) begin
        done  = 1'b1;
        m_cnt = 0;
      end
    end
    if (done) begin
      if (!m_valid || r) begin
        m_valid = 1'b1;
        m_out   = m_sum;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
  endfunction

  logic [63:0]   all1;
  logic [AW-1:0] gsum;
  int            k;

  initial begin
    all1 = '1;

    // reset state, no clock edge needed
    #12;
    check("reset out_valid", AW'(out_valid), '0);
    check("reset acc_out", acc_out, '0);
    check("reset tap_cnt", AW'(tap_cnt), '0);
    check("reset busy", AW'(busy), '0);
    check("reset overflow", AW'(overflow), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic window 1..9
    for (int i = 1; i <= 9; i++) add(0, 1, 64'(i), 1, i == 9, 72'd45, i % 9, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    // width limit
    for (int i = 1; i <= 9; i++) add(0, 1, all1, 1, i == 9, 72'h8_FFFF_FFFF_FFFF_FFF7, i % 9, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    // simultaneous retire and load
    for (int i = 1; i <= 9; i++) add(0, 1, 1, 0, i == 9, 72'd9, i % 9, 0);
    for (int i = 1; i <= 8; i++) add(0, 1, 2, 0, 1, 72'd9, i, 0);
    add(0, 1, 2, 1, 1, 72'd18, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    // back-pressure: second window dropped, third window delivered after retire
    for (int i = 1; i <= 9; i++) add(0, 1, 1, 0, i == 9, 72'd9, i % 9, 0);
    for (int i = 1; i <= 9; i++) add(0, 1, 1, 0, 1, 72'd9, i % 9, i == 9);
    add(0, 0, 0, 1, 0, 0, 0, 1);
    for (int i = 1; i <= 9; i++) add(0, 1, 2, 0, i == 9, 72'd18, i % 9, 1);
    // clear beats a pending output, overflow and a concurrent prod_valid
    add(1, 1, 5, 0, 0, 0, 0, 0);
    add(0, 1, 7, 0, 0, 0, 1, 0);
    add(1, 1, 7, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].clr, tbl[i].pv, tbl[i].p, tbl[i].rdy);
      check($sformatf("tbl[%0d] out_valid", i), AW'(out_valid), AW'(tbl[i].ev));
      check($sformatf("tbl[%0d] tap_cnt", i), AW'(tap_cnt), AW'(tbl[i].etap));
      check($sformatf("tbl[%0d] busy", i), AW'(busy), AW'(tbl[i].etap != 0));
      check($sformatf("tbl[%0d] overflow", i), AW'(overflow), AW'(tbl[i].eovf));
      if (tbl[i].ev) check($sformatf("tbl[%0d] acc_out", i), acc_out, tbl[i].eacc);
    end

    // gapped input with idle gaps of 0..5 cycles
    gsum = '0;
    for (int i = 1; i <= 9; i++) begin
      logic [63:0] p;
      int gap;
      p = {$urandom, $urandom};
      gsum = gsum + AW'(p);
      drive(0, 1, p, 1);
      check($sformatf("gap tap %0d busy", i), AW'(busy), AW'(i < 9));
      if (i < 9) begin
        gap = $urandom_range(5, 0);
        for (int g = 0; g < gap; g++) begin
          drive(0, 0, 0, 1);
          check("gap idle busy", AW'(busy), 1);
          check("gap idle tap_cnt", AW'(tap_cnt), AW'(i));
        end
      end
    end
    check("gap out_valid", AW'(out_valid), 1);
    check("gap acc_out", acc_out, gsum);
    drive(0, 0, 0, 1);

    // clear after 4 taps, then a full window of 3s
    for (int i = 0; i < 4; i++) drive(0, 1, 3, 1);
    drive(1, 0, 0, 1);
    check("flush tap_cnt", AW'(tap_cnt), 0);
    for (int i = 0; i < 9; i++) drive(0, 1, 3, 1);
    check("flush out_valid", AW'(out_valid), 1);
    check("flush acc_out", acc_out, 72'd27);

    // asynchronous reset mid-window
    drive(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 4, 0);
    check("pre-reset tap_cnt", AW'(tap_cnt), 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", AW'(out_valid), 0);
    check("async rst acc_out", acc_out, 0);
    check("async rst tap_cnt", AW'(tap_cnt), 0);
    check("async rst busy", AW'(busy), 0);
    check("async rst overflow", AW'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, 4, 1);
    check("post-reset tap_cnt", AW'(tap_cnt), 1);
    for (int i = 0; i < 8; i++) drive(0, 1, 4, 1);
    check("post-reset out_valid", AW'(out_valid), 1);
    check("post-reset acc_out", acc_out, 72'd36);

    // randomized traffic against the reference model
    drive(1, 0, 0, 0);
    model_step(1, 0, 0, 0);
    m_out = '0;
    for (int i = 0; i < 3000; i++) begin
      logic c, pv, r;
      logic [63:0] p;
      c  = ($urandom_range(59, 0) == 0);
      pv = ($urandom_range(3, 0) != 0);
      r  = ($urandom_range(2, 0) != 0);
      k  = $urandom_range(2, 0);
      p  = (k == 0) ? all1 : {$urandom, $urandom};
      drive(c, pv, p, r);
      model_step(c, pv, p, r);
      check("rnd out_valid", AW'(out_valid), AW'(m_valid));
      check("rnd tap_cnt", AW'(tap_cnt), AW'(m_cnt));
      check("rnd overflow", AW'(overflow), AW'(m_ovf));
      if (m_valid) check("rnd acc_out", acc_out, m_out);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
